bbox_tracker: RTL and testbench
===============================

// Module: bbox_tracker
// PURPOSE
// - Upstream feeder for the image-header writer: watches a raster pixel stream and tracks the
//   bounding box (xMin/xMax/yMin/yMax) of foreground pixels over one frame.
// - At frame end, presents the box and pulses start to the header writer.
// - Then waits for the writer's done before it accepts a new frame.
// PARAMETERS
// - COORD_W  11   coordinate width; matches header writer xMin..yMax ports
// - X_RES    640  frame width; pixels with pix_x >= X_RES are ignored
// - Y_RES    480  frame height; pixels with pix_y >= Y_RES are ignored
// PORTS
// - clk          in   1        clock
// - rst_n        in   1        reset, synchronous, active-low
// - frame_start  in   1        1-cycle pulse: a new frame begins
// - frame_end    in   1        1-cycle pulse: last pixel of the frame (may coincide with it)
// - pix_valid    in   1        pix_x/pix_y/pix_fg valid this cycle
// - pix_x        in   COORD_W  pixel column
// - pix_y        in   COORD_W  pixel row
// - pix_fg       in   1        pixel is foreground
// - xMin,xMax    out  COORD_W  box columns, to header writer
// - yMin,yMax    out  COORD_W  box rows, to header writer
// - hdr_start    out  1        1-cycle start pulse to header writer
// - hdr_done     in   1        header writer done (level; held high while it idles finished)
// - busy         out  1        high in every state except IDLE
// - bbox_valid   out  1        1-cycle pulse: header write for this frame completed
// - bbox_empty   out  1        last completed frame had no foreground pixels
// - frame_drop   out  1        1-cycle pulse: frame_start ignored because not IDLE
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE.
//   Tracking regs: min = all-ones, max = 0, fg_seen = 0.
// - FSM states: IDLE -> TRACK -> LAUNCH -> WAIT -> DONE -> IDLE.
// - IDLE
//   - On frame_start: re-init tracking regs (min = all-ones, max = 0, fg_seen = 0) and go to TRACK.
//   - Pixels presented on the frame_start cycle are not accepted.
// - TRACK
//   - A pixel updates the box when pix_valid && pix_fg && pix_x < X_RES && pix_y < Y_RES.
//   - Update: min = min(min, coord); max = max(max, coord); fg_seen = 1.
//   - Comparisons are unsigned, COORD_W bits.
//   - On frame_end: the same-cycle pixel is included, then go to LAUNCH.
// - LAUNCH (exactly 1 cycle)
//   - Load output regs xMin..yMax from the tracking regs.
//   - If fg_seen == 0: outputs are all 0 and bbox_empty = 1; otherwise bbox_empty = 0.
//   - hdr_start is registered: high during the cycle after LAUNCH (first WAIT cycle), exactly 1 cycle.
//   - xMin..yMax are already stable when hdr_start rises and stay stable until the next LAUNCH.
// - WAIT
//   - hdr_done is ignored in the first 2 WAIT cycles, to mask a stale done from the previous frame.
//   - After that, hdr_done == 1 -> DONE.
//   - No timeout; the block stays in WAIT until done.
// - DONE (1 cycle): bbox_valid = 1, then go to IDLE.
// - frame_start outside IDLE: ignored, frame_drop pulses the next cycle, state unchanged.
// - frame_end outside TRACK, and pixels outside TRACK: ignored.
// - frame_start and frame_end in the same cycle in IDLE: enter TRACK only; the frame_end is ignored.
// - Width rules
//   - Box guaranteed xMin <= xMax and yMin <= yMax when non-empty.
//   - Single-pixel box gives min == max.
//   - The header writer computes the area downstream; no arithmetic here beyond compares.
// - Reset mid-operation (any state)
//   - Returns to IDLE on the next edge; all outputs 0.
//   - hdr_start is never emitted for a partially tracked frame.
// TESTING
// - Two fg pixels (10,20) and (100,5), then frame_end:
//   -> xMin=10, xMax=100, yMin=5, yMax=20; one hdr_start pulse; bbox_empty=0.
// - Frame with no fg pixels:
//   -> all box outputs 0; bbox_empty=1; hdr_start still pulses; bbox_valid after hdr_done.
// - fg pixel (639,479) on the same cycle as frame_end; also (640,0) presented:
//   -> box = (639,639,479,479); (640,0) ignored.
// - hdr_done held high from start, then dropped 1 cycle after hdr_start, then raised 4 cycles later
//   -> bbox_valid exactly 1 cycle after the raise, not earlier.
// - frame_start during WAIT -> frame_drop pulse; box unchanged; next frame_start in IDLE accepted.
// - rst_n low for 1 cycle during TRACK
//   -> IDLE, outputs 0, no hdr_start; next frame tracks from fresh min/max.

Source files
------------

// File: rtl/bbox_tracker.sv
// ---------------------------------------------------------------------------
// bbox_tracker
//   Watches a raster pixel stream and tracks the bounding box of foreground
//   pixels over one frame. At frame end it presents the box to the image
//   header writer, pulses hdr_start, and then waits for hdr_done before it
//   accepts another frame.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   frame_start, frame_end  1-cycle frame delimiters
//   pix_valid/x/y/fg        pixel stream (fg = foreground)
//   xMin,xMax,yMin,yMax     box presented to the header writer
//   hdr_start               1-cycle start pulse to the header writer
//   hdr_done                header writer done (level)
//   busy                    high whenever not idle
//   bbox_valid              1-cycle pulse: header write for this frame done
//   bbox_empty              last launched frame had no foreground pixels
//   frame_drop              1-cycle pulse: a frame_start was ignored
// ---------------------------------------------------------------------------
module bbox_tracker #(
  parameter int COORD_W = 11,
  parameter int X_RES   = 640,
  parameter int Y_RES   = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               pix_fg,
  output logic [COORD_W-1:0] xMin,
  output logic [COORD_W-1:0] xMax,
  output logic [COORD_W-1:0] yMin,
  output logic [COORD_W-1:0] yMax,
  output logic               hdr_start,
  input  logic               hdr_done,
  output logic               busy,
  output logic               bbox_valid,
  output logic               bbox_empty,
  output logic               frame_drop
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_RES);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_RES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRACK,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [COORD_W-1:0] r_xmin;
  logic [COORD_W-1:0] r_xmax;
  logic [COORD_W-1:0] r_ymin;
  logic [COORD_W-1:0] r_ymax;
  logic               r_fg_seen;
  logic [1:0]         r_wait_cnt;

  logic [COORD_W-1:0] r_xmin_out;
  logic [COORD_W-1:0] r_xmax_out;
  logic [COORD_W-1:0] r_ymin_out;
  logic [COORD_W-1:0] r_ymax_out;
  logic               r_empty;
  logic               r_hdr_start;
  logic               r_frame_drop;

  logic w_pix_hit;
  logic w_wait_armed;

  assign w_pix_hit = (r_state == S_TRACK) && pix_valid && pix_fg &&
                     (pix_x < X_LIM) && (pix_y < Y_LIM);

  // hdr_done is only honoured from the third WAIT cycle on, so a done left
  // high by the writer from the previous frame cannot end this one early.
  assign w_wait_armed = (r_wait_cnt == 2'd2);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (frame_start) w_next = S_TRACK;
      S_TRACK:  if (frame_end) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (w_wait_armed && hdr_done) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic decoded from state
  always_comb begin
    busy       = (r_state != S_IDLE);
    bbox_valid = (r_state == S_DONE);
  end

  // Tracking registers; the pixel on the frame_end cycle is still in TRACK
  // and is therefore folded in before LAUNCH reads these registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xmin    <= '1;
      r_xmax    <= '0;
      r_ymin    <= '1;
      r_ymax    <= '0;
      r_fg_seen <= 1'b0;
    end else if ((r_state == S_IDLE) && frame_start) begin
      r_xmin    <= '1;
      r_xmax    <= '0;
      r_ymin    <= '1;
      r_ymax    <= '0;
      r_fg_seen <= 1'b0;
    end else if (w_pix_hit) begin
      if (pix_x < r_xmin) r_xmin <= pix_x;
      if (pix_x > r_xmax) r_xmax <= pix_x;
      if (pix_y < r_ymin) r_ymin <= pix_y;
      if (pix_y > r_ymax) r_ymax <= pix_y;
      r_fg_seen <= 1'b1;
    end
  end

  // WAIT-cycle counter, saturating once done becomes eligible
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_wait_cnt <= '0;
    end else if (!w_wait_armed) begin
      r_wait_cnt <= r_wait_cnt + 2'd1;
    end
  end

  // Registered outputs: the box is loaded on the same edge that raises
  // hdr_start, so it is stable for the whole start cycle and afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xmin_out   <= '0;
      r_xmax_out   <= '0;
      r_ymin_out   <= '0;
      r_ymax_out   <= '0;
      r_empty      <= 1'b0;
      r_hdr_start  <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_hdr_start  <= (r_state == S_LAUNCH);
      r_frame_drop <= frame_start && (r_state != S_IDLE);
      if (r_state == S_LAUNCH) begin
        if (r_fg_seen) begin
          r_xmin_out <= r_xmin;
          r_xmax_out <= r_xmax;
          r_ymin_out <= r_ymin;
          r_ymax_out <= r_ymax;
          r_empty    <= 1'b0;
        end else begin
          r_xmin_out <= '0;
          r_xmax_out <= '0;
          r_ymin_out <= '0;
          r_ymax_out <= '0;
          r_empty    <= 1'b1;
        end
      end
    end
  end

  assign xMin       = r_xmin_out;
  assign xMax       = r_xmax_out;
  assign yMin       = r_ymin_out;
  assign yMax       = r_ymax_out;
  assign bbox_empty = r_empty;
  assign hdr_start  = r_hdr_start;
  assign frame_drop = r_frame_drop;

endmodule

// File: tb/tb_bbox_tracker.sv
// ---------------------------------------------------------------------------
// tb_bbox_tracker
//   Directed and randomized frames against a reference model that keeps the
//   box as plain integers (first foreground pixel seeds it, later ones widen
//   it). Handshake timing is expressed as WAIT-cycle indices.
// ---------------------------------------------------------------------------
module tb_bbox_tracker;

  localparam int CW = 11;
  localparam int XR = 640;
  localparam int YR = 480;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic          pix_valid = 1'b0;
  logic [CW-1:0] pix_x = '0;
  logic [CW-1:0] pix_y = '0;
  logic          pix_fg = 1'b0;
  logic          hdr_done = 1'b0;
  logic [CW-1:0] xMin, xMax, yMin, yMax;
  logic          hdr_start, busy, bbox_valid, bbox_empty, frame_drop;

  bbox_tracker #(.COORD_W(CW), .X_RES(XR), .Y_RES(YR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_fg     (pix_fg),
    .xMin       (xMin),
    .xMax       (xMax),
    .yMin       (yMin),
    .yMax       (yMax),
    .hdr_start  (hdr_start),
    .hdr_done   (hdr_done),
    .busy       (busy),
    .bbox_valid (bbox_valid),
    .bbox_empty (bbox_empty),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int x;
    int y;
    bit v;
    bit fg;
  } pix_t;

  pix_t frame_q[$];

  // reference model state
  int m_xmin, m_xmax, m_ymin, m_ymax;
  bit m_seen;
  // box expected on the outputs after the last launch
  int e_xmin, e_xmax, e_ymin, e_ymax;
  bit e_empty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    frame_start = 1'b0;
    frame_end   = 1'b0;
    pix_valid   = 1'b0;
    pix_fg      = 1'b0;
  endtask

  task automatic add_pix(input int x, input int y, input bit v, input bit fg);
    pix_t p;
    p.x = x; p.y = y; p.v = v; p.fg = fg;
    frame_q.push_back(p);
  endtask

  task automatic model_pixel(input pix_t p);
    if (p.v && p.fg && p.x < XR && p.y < YR) begin
      if (!m_seen) begin
        m_xmin = p.x; m_xmax = p.x; m_ymin = p.y; m_ymax = p.y;
      end else begin
        if (p.x < m_xmin) m_xmin = p.x;
        if (p.x > m_xmax) m_xmax = p.x;
        if (p.y < m_ymin) m_ymin = p.y;
        if (p.y > m_ymax) m_ymax = p.y;
      end
      m_seen = 1'b1;
    end
  endtask

  task automatic check_box(input string tag);
    chk({tag, "_xMin"}, 32'(xMin), e_xmin);
    chk({tag, "_xMax"}, 32'(xMax), e_xmax);
    chk({tag, "_yMin"}, 32'(yMin), e_ymin);
    chk({tag, "_yMax"}, 32'(yMax), e_ymax);
    chk({tag, "_empty"}, 32'(bbox_empty), 32'(e_empty));
  endtask

  // Start a frame (a fg pixel at (0,0) rides on the start cycle and must be
  // ignored), stream frame_q with frame_end on the last pixel, then check the
  // launch cycle and the hdr_start cycle.
  task automatic send_frame(input bit fe_with_start);
    frame_start = 1'b1;
    frame_end   = fe_with_start;
    pix_valid   = 1'b1;
    pix_fg      = 1'b1;
    pix_x       = '0;
    pix_y       = '0;
    step();
    idle_in();
    chk("busy_after_start", 32'(busy), 1);
    m_seen = 1'b0;
    if (frame_q.size() == 0) begin
      frame_end = 1'b1;
      step();
    end else begin
      foreach (frame_q[i]) begin
        pix_x     = CW'(frame_q[i].x);
        pix_y     = CW'(frame_q[i].y);
        pix_valid = frame_q[i].v;
        pix_fg    = frame_q[i].fg;
        frame_end = (i == frame_q.size() - 1);
        model_pixel(frame_q[i]);
        step();
      end
    end
    idle_in();
    chk("hdr_start_launch", 32'(hdr_start), 0);
    chk("busy_launch", 32'(busy), 1);
    step();
    e_empty = !m_seen;
    e_xmin  = m_seen ? m_xmin : 0;
    e_xmax  = m_seen ? m_xmax : 0;
    e_ymin  = m_seen ? m_ymin : 0;
    e_ymax  = m_seen ? m_ymax : 0;
    chk("hdr_start_pulse", 32'(hdr_start), 1);
    check_box("launch");
    frame_q.delete();
  endtask

  // WAIT cycle w=1 is the hdr_start cycle. hdr_done is driven high in cycle 1
  // when stale is set, and from cycle raise_at onwards. The first cycle w>=3
  // with done high is followed by the bbox_valid cycle. frame_start is pulsed
  // in cycle drop_at (0 = never) and must show up as frame_drop next cycle.
  task automatic handshake(input int raise_at, input bit stale, input int drop_at);
    int w;
    bit got, exp_v, exp_d;
    w = 1;
    got = 1'b0;
    while (!got && w < 24) begin
      hdr_done    = (stale && w == 1) || (w >= raise_at);
      frame_start = (w == drop_at);
      exp_v       = hdr_done && (w >= 3);
      exp_d       = frame_start;
      step();
      w++;
      frame_start = 1'b0;
      chk("bbox_valid", 32'(bbox_valid), 32'(exp_v));
      chk("frame_drop", 32'(frame_drop), 32'(exp_d));
      chk("hdr_start_single", 32'(hdr_start), 0);
      if (exp_v) got = 1'b1;
    end
    hdr_done = 1'b0;
    check_box("hold");
    step();
    chk("busy_idle", 32'(busy), 0);
    chk("bbox_valid_end", 32'(bbox_valid), 0);
    chk("frame_drop_end", 32'(frame_drop), 0);
  endtask

  int n;
  int raise_at, drop_at;
  bit stale, fe_start;

  initial begin
    idle_in();
    hdr_done = 1'b0;
    rst_n    = 1'b0;
    step();
    step();
    chk("rst_xMin", 32'(xMin), 0);
    chk("rst_xMax", 32'(xMax), 0);
    chk("rst_yMin", 32'(yMin), 0);
    chk("rst_yMax", 32'(yMax), 0);
    chk("rst_hdr_start", 32'(hdr_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bbox_valid", 32'(bbox_valid), 0);
    chk("rst_bbox_empty", 32'(bbox_empty), 0);
    chk("rst_frame_drop", 32'(frame_drop), 0);
    rst_n = 1'b1;

    // pixel and frame_end while idle are ignored
    pix_valid = 1'b1; pix_fg = 1'b1; frame_end = 1'b1;
    step();
    idle_in();
    chk("idle_frame_end", 32'(busy), 0);

    // two foreground pixels, one background in between
    add_pix(10, 20, 1, 1); add_pix(50, 50, 1, 0); add_pix(100, 5, 1, 1);
    send_frame(1'b0);
    handshake(3, 1'b0, 0);

    // no qualifying foreground: background, out of range, not valid
    add_pix(30, 30, 1, 0); add_pix(700, 10, 1, 1); add_pix(15, 15, 0, 1);
    send_frame(1'b0);
    handshake(5, 1'b0, 0);

    // edge of frame: (640,0) and (0,480) ignored, (639,479) with frame_end
    add_pix(640, 0, 1, 1); add_pix(0, 480, 1, 1); add_pix(639, 479, 1, 1);
    send_frame(1'b0);
    handshake(3, 1'b1, 0);

    // single pixel; done high at start, dropped, raised four cycles later
    add_pix(7, 9, 1, 1);
    send_frame(1'b0);
    handshake(6, 1'b1, 0);

    // frame_start during WAIT is dropped and the box holds
    add_pix(200, 300, 1, 1); add_pix(201, 100, 1, 1);
    send_frame(1'b0);
    handshake(5, 1'b0, 2);

    // start and end together in IDLE: only the start counts
    add_pix(3, 4, 1, 1); add_pix(600, 400, 1, 1);
    send_frame(1'b1);
    handshake(3, 1'b0, 0);

    // reset during TRACK
    frame_start = 1'b1;
    step();
    idle_in();
    pix_valid = 1'b1; pix_fg = 1'b1; pix_x = 11'd1; pix_y = 11'd1;
    step();
    pix_x = 11'd2; pix_y = 11'd2; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_in();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_xMin", 32'(xMin), 0);
    chk("midrst_xMax", 32'(xMax), 0);
    chk("midrst_yMin", 32'(yMin), 0);
    chk("midrst_yMax", 32'(yMax), 0);
    chk("midrst_hdr_start", 32'(hdr_start), 0);
    frame_end = 1'b1;
    step();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      chk("midrst_no_start", 32'(hdr_start), 0);
      chk("midrst_idle", 32'(busy), 0);
      step();
    end

    // fresh frame after the reset
    add_pix(300, 200, 1, 1); add_pix(310, 210, 1, 1);
    send_frame(1'b0);
    handshake(3, 1'b0, 0);

    // randomized frames
    for (int f = 0; f < 14; f++) begin
      n = int'($urandom_range(0, 20));
      for (int k = 0; k < n; k++) begin
        add_pix(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end
      fe_start = ($urandom_range(0, 3) == 0);
      raise_at = int'($urandom_range(1, 8));
      stale    = ($urandom_range(0, 1) == 1);
      drop_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_frame(fe_start);
      handshake(raise_at, stale, drop_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
